// File: rtl/periph_io_ctrl_pkg.sv
// Shared constants, register map and bus types for the peripheral I/O controller.
package periph_io_ctrl_pkg;

  localparam int unsigned N_IN    = 19;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LED_W   = 16;
  localparam int unsigned COLOR_W = 3;
  localparam int unsigned DUTY_W  = 8;
  localparam int unsigned TONE_W  = 20;

  // RGB register field positions
  localparam int unsigned RGB_C0_LSB   = 0;
  localparam int unsigned RGB_C1_LSB   = 3;
  localparam int unsigned RGB_DUTY_LSB = 8;

  // Register word indices
  localparam logic [ADDR_W-1:0] REG_IN_STATE = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] REG_IN_EDGE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] REG_LED      = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] REG_RGB      = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] REG_TONE     = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] REG_IRQ_MASK = ADDR_W'(5);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } bus_state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_cmd_t;

endpackage

// File: rtl/periph_io_ctrl_if.sv
// CPU-side register bus: one request per two cycles, single-cycle ack pulse.
interface periph_io_ctrl_if;
  import periph_io_ctrl_pkg::*;

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (output bus_req, bus_we, bus_addr, bus_wdata,
                  input  bus_ack, bus_rdata);
  modport slave  (input  bus_req, bus_we, bus_addr, bus_wdata,
                  output bus_ack, bus_rdata);
endinterface

// File: rtl/periph_io_ctrl_input_debounce.sv
// One board input: 2-flop synchronizer followed by a consecutive-difference debouncer.
module input_debounce #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic state,
  output logic rise_c
);

  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             differ_c;
  logic             commit_c;

  // Commit happens on the cycle the counter has seen DB_CYCLES differing samples
  always_comb begin
    differ_c = sync[1] ^ state;
    commit_c = differ_c && (cnt == CNT_LAST);
    rise_c   = commit_c && sync[1];
  end

  // Synchronizer chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b00;
    else        sync <= {sync[0], raw};
  end

  // Debounce counter and stable state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      state <= 1'b0;
    end else if (!differ_c) begin
      cnt <= '0;
    end else if (commit_c) begin
      cnt   <= '0;
      state <= sync[1];
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/periph_io_ctrl.sv
// Memory-mapped board I/O: debounced inputs with edge IRQ, LEDs, PWM RGB and tone output.
module periph_io_ctrl
  import periph_io_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  periph_io_ctrl_if.slave    bus,
  input  logic [N_IN-1:0]    switches_and_buttons,
  output logic               irq,
  output logic [LED_W-1:0]   LEDs,
  output logic [COLOR_W-1:0] RBG_0,
  output logic [COLOR_W-1:0] RBG_1,
  output logic               sound_L,
  output logic               sound_R
);

  bus_state_e        state, state_next;
  bus_cmd_t          cmd_c;
  logic              accept_c, ack_next;
  logic [DATA_W-1:0] rd_val_c, rdata_next;
  logic              wr_c;

  logic [N_IN-1:0]    in_state, rise_c, in_edge, in_edge_next, irq_mask, irq_mask_next;
  logic [COLOR_W-1:0] col0, col1;
  logic [DUTY_W-1:0]  duty, pwm_cnt;
  logic [TONE_W-1:0]  tone, tone_cnt;

  // Per-bit synchronizer/debouncer
  for (genvar i = 0; i < N_IN; i++) begin : g_in
    input_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk    (clk),
      .rst_n  (rst),
      .raw    (switches_and_buttons[i]),
      .state  (in_state[i]),
      .rise_c (rise_c[i])
    );
  end

  // Bus command view and read mux of current register contents
  always_comb begin
    cmd_c = '{we: bus.bus_we, addr: bus.bus_addr, wdata: bus.bus_wdata};
    rd_val_c = '0;
    case (cmd_c.addr)
      REG_IN_STATE: rd_val_c = DATA_W'(in_state);
      REG_IN_EDGE:  rd_val_c = DATA_W'(in_edge);
      REG_LED:      rd_val_c = DATA_W'(LEDs);
      REG_RGB:      rd_val_c = DATA_W'({duty, 2'b00, col1, col0});
      REG_TONE:     rd_val_c = DATA_W'(tone);
      REG_IRQ_MASK: rd_val_c = DATA_W'(irq_mask);
      default:      rd_val_c = '0;
    endcase
  end

  // Bus FSM next state and registered ack/rdata values
  always_comb begin
    state_next = state;
    ack_next   = 1'b0;
    rdata_next = '0;
    accept_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.bus_req) begin
          state_next = ST_ACK;
          ack_next   = 1'b1;
          accept_c   = 1'b1;
          if (!cmd_c.we) rdata_next = rd_val_c;
        end
      end
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      bus.bus_ack   <= 1'b0;
      bus.bus_rdata <= '0;
    end else begin
      state         <= state_next;
      bus.bus_ack   <= ack_next;
      bus.bus_rdata <= rdata_next;
    end
  end

  // Edge latch with W1C (set wins) and mask update
  always_comb begin
    wr_c = accept_c && cmd_c.we;
    in_edge_next = in_edge | rise_c;
    if (wr_c && cmd_c.addr == REG_IN_EDGE)
      in_edge_next = (in_edge & ~cmd_c.wdata[N_IN-1:0]) | rise_c;
    irq_mask_next = irq_mask;
    if (wr_c && cmd_c.addr == REG_IRQ_MASK) irq_mask_next = cmd_c.wdata[N_IN-1:0];
  end

  // Control registers and interrupt output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_edge  <= '0;
      irq_mask <= '0;
      irq      <= 1'b0;
      LEDs     <= '0;
      col0     <= '0;
      col1     <= '0;
      duty     <= '0;
    end else begin
      in_edge  <= in_edge_next;
      irq_mask <= irq_mask_next;
      irq      <= |(in_edge_next & irq_mask_next);
      if (wr_c && cmd_c.addr == REG_LED) LEDs <= cmd_c.wdata[LED_W-1:0];
      if (wr_c && cmd_c.addr == REG_RGB) begin
        col0 <= cmd_c.wdata[RGB_C0_LSB +: COLOR_W];
        col1 <= cmd_c.wdata[RGB_C1_LSB +: COLOR_W];
        duty <= cmd_c.wdata[RGB_DUTY_LSB +: DUTY_W];
      end
    end
  end

  // Free-running PWM for the two RGB LEDs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt <= '0;
      RBG_0   <= '0;
      RBG_1   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + DUTY_W'(1);
      RBG_0   <= (pwm_cnt < duty) ? col0 : '0;
      RBG_1   <= (pwm_cnt < duty) ? col1 : '0;
    end
  end

  // Square-wave tone: toggle every TONE cycles, silent when TONE is zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tone     <= '0;
      tone_cnt <= '0;
      sound_L  <= 1'b0;
    end else if (wr_c && cmd_c.addr == REG_TONE) begin
      tone     <= cmd_c.wdata[TONE_W-1:0];
      tone_cnt <= '0;
      sound_L  <= 1'b0;
    end else if (tone == '0) begin
      tone_cnt <= '0;
      sound_L  <= 1'b0;
    end else if (tone_cnt == tone - TONE_W'(1)) begin
      tone_cnt <= '0;
      sound_L  <= ~sound_L;
    end else begin
      tone_cnt <= tone_cnt + TONE_W'(1);
    end
  end

  // Right channel mirrors left
  always_comb sound_R = sound_L;

endmodule

// File: tb/tb_periph_io_ctrl.sv
// Directed self-checking bench for periph_io_ctrl (DB_CYCLES = 4).
module tb_periph_io_ctrl;
  import periph_io_ctrl_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_IN-1:0]  sw;
  logic             irq;
  logic [LED_W-1:0] leds;
  logic [2:0]       rbg0, rbg1;
  logic             snd_l, snd_r;
  int               total = 0;
  int               bad = 0;

  periph_io_ctrl_if bif ();

  periph_io_ctrl #(.DB_CYCLES(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .bus                  (bif),
    .switches_and_buttons (sw),
    .irq                  (irq),
    .LEDs                 (leds),
    .RBG_0                (rbg0),
    .RBG_1                (rbg1),
    .sound_L              (snd_l),
    .sound_R              (snd_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one transaction; returns in the ack cycle (#1 after the edge)
  task automatic bus_op(input logic we, input logic [2:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata);
    logic got;
    got = 1'b0;
    @(negedge clk);
    bif.bus_req = 1'b1; bif.bus_we = we; bif.bus_addr = addr; bif.bus_wdata = wdata;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (bif.bus_ack === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    rdata = bif.bus_rdata;
    bif.bus_req = 1'b0;
    check("bus_ack_seen", 32'(got), 32'd1);
  endtask

  task automatic pwm_measure(input logic [31:0] rgb, input int exp_on, input string name);
    logic [31:0] rd;
    int on, stray;
    bus_op(1'b1, REG_RGB, rgb, rd);
    repeat (2) @(posedge clk);
    on = 0;
    stray = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      if (rbg0 === 3'b101) on++;
      else if (rbg0 !== 3'b000) stray++;
      if (rbg1 !== 3'b000) stray++;
    end
    check({name, "_on"}, 32'(on), 32'(exp_on));
    check({name, "_stray"}, 32'(stray), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},   32'(bif.bus_ack), 32'd0);
    check({tag, "_rdata"}, bif.bus_rdata,    32'd0);
    check({tag, "_irq"},   32'(irq),         32'd0);
    check({tag, "_leds"},  32'(leds),        32'd0);
    check({tag, "_rbg0"},  32'(rbg0),        32'd0);
    check({tag, "_rbg1"},  32'(rbg1),        32'd0);
    check({tag, "_sndl"},  32'(snd_l),       32'd0);
    check({tag, "_sndr"},  32'(snd_r),       32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int nz;

    vecs[0]  = '{1'b1, REG_LED,      32'h0000A5A5, 32'h0};
    vecs[1]  = '{1'b0, REG_LED,      32'h0,        32'h0000A5A5};
    vecs[2]  = '{1'b1, REG_IRQ_MASK, 32'hFFFFFFFF, 32'h0};
    vecs[3]  = '{1'b0, REG_IRQ_MASK, 32'h0,        32'h0007FFFF};
    vecs[4]  = '{1'b1, REG_RGB,      32'hFFFFFFFF, 32'h0};
    vecs[5]  = '{1'b0, REG_RGB,      32'h0,        32'h0000FF3F};
    vecs[6]  = '{1'b1, REG_TONE,     32'hFFFFFFFF, 32'h0};
    vecs[7]  = '{1'b0, REG_TONE,     32'h0,        32'h000FFFFF};
    vecs[8]  = '{1'b1, 3'd6,         32'h00001234, 32'h0};
    vecs[9]  = '{1'b0, 3'd6,         32'h0,        32'h0};
    vecs[10] = '{1'b0, 3'd7,         32'h0,        32'h0};
    vecs[11] = '{1'b1, REG_IN_STATE, 32'h0000FFFF, 32'h0};
    vecs[12] = '{1'b0, REG_IN_STATE, 32'h0,        32'h0};
    vecs[13] = '{1'b1, REG_LED,      32'hFFFF1234, 32'h0};
    vecs[14] = '{1'b0, REG_LED,      32'h0,        32'h00001234};
    vecs[15] = '{1'b1, REG_IRQ_MASK, 32'h0,        32'h0};
    vecs[16] = '{1'b1, REG_RGB,      32'h0,        32'h0};
    vecs[17] = '{1'b1, REG_TONE,     32'h0,        32'h0};
    vecs[18] = '{1'b0, REG_IN_EDGE,  32'h0,        32'h0};

    rst = 1'b0;
    sw = '0;
    bif.bus_req = 1'b0; bif.bus_we = 1'b0; bif.bus_addr = '0; bif.bus_wdata = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");

    // First request accepted on the first edge after release
    @(negedge clk);
    bif.bus_req = 1'b1; bif.bus_we = 1'b0; bif.bus_addr = REG_LED;
    rst = 1'b1;
    @(posedge clk); #1;
    check("first_edge_ack", 32'(bif.bus_ack), 32'd1);
    check("first_edge_rdata", bif.bus_rdata, 32'd0);
    bif.bus_req = 1'b0;

    // Register map vectors
    foreach (vecs[i]) begin
      bus_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
    end

    // LED write visible in ack cycle; held request acked every second cycle
    bus_op(1'b1, REG_LED, 32'h0000A5A5, rd);
    check("led_at_ack", 32'(leds), 32'h0000A5A5);
    @(negedge clk);
    @(negedge clk);
    bif.bus_req = 1'b1; bif.bus_we = 1'b0; bif.bus_addr = REG_LED;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("held_ack%0d", k), 32'(bif.bus_ack), (k % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("held_rdata%0d", k), bif.bus_rdata, (k % 2 == 0) ? 32'h0000A5A5 : 32'd0);
    end
    bif.bus_req = 1'b0;

    // Debounced rise on bit 1
    @(negedge clk); sw = 19'h00002;
    repeat (10) @(negedge clk);
    bus_op(1'b0, REG_IN_STATE, 32'h0, rd);
    check("db_in_state", rd, 32'h00000002);
    bus_op(1'b0, REG_IN_EDGE, 32'h0, rd);
    check("db_in_edge", rd, 32'h00000002);

    // Two-cycle glitch on bit 2 is filtered out
    @(negedge clk); sw = 19'h00006;
    @(negedge clk);
    @(negedge clk); sw = 19'h00002;
    repeat (10) @(negedge clk);
    bus_op(1'b0, REG_IN_STATE, 32'h0, rd);
    check("glitch_in_state", rd, 32'h00000002);
    bus_op(1'b0, REG_IN_EDGE, 32'h0, rd);
    check("glitch_in_edge", rd, 32'h00000002);

    // Interrupt mask and W1C clear
    bus_op(1'b1, REG_IRQ_MASK, 32'h2, rd);
    check("irq_masked_on", 32'(irq), 32'd1);
    bus_op(1'b1, REG_IN_EDGE, 32'h2, rd);
    check("irq_cleared", 32'(irq), 32'd0);
    bus_op(1'b0, REG_IN_EDGE, 32'h0, rd);
    check("edge_cleared", rd, 32'h0);

    // Clear coinciding with a fresh rise: set wins
    @(negedge clk); sw = '0;
    repeat (10) @(negedge clk);
    sw = 19'h00002;
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    check("irq_before_rise", 32'(irq), 32'd0);
    @(negedge clk);
    bif.bus_req = 1'b1; bif.bus_we = 1'b1; bif.bus_addr = REG_IN_EDGE; bif.bus_wdata = 32'h2;
    @(posedge clk); #1;
    check("coincide_ack", 32'(bif.bus_ack), 32'd1);
    check("coincide_irq", 32'(irq), 32'd1);
    bif.bus_req = 1'b0;
    bus_op(1'b0, REG_IN_EDGE, 32'h0, rd);
    check("coincide_edge", rd, 32'h00000002);
    @(negedge clk); sw = '0;

    // PWM duty
    pwm_measure(32'h00008005, 128, "pwm_half");
    pwm_measure(32'h00000005, 0,   "pwm_off");
    pwm_measure(32'h0000FF05, 255, "pwm_full");

    // Tone generator
    bus_op(1'b1, REG_TONE, 32'd10, rd);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      check($sformatf("tone_l_%0d", i), 32'(snd_l), 32'((i / 10) % 2));
      check($sformatf("tone_r_%0d", i), 32'(snd_r), 32'((i / 10) % 2));
    end
    bus_op(1'b1, REG_TONE, 32'd0, rd);
    nz = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (snd_l !== 1'b0 || snd_r !== 1'b0) nz++;
    end
    check("tone_zero_silent", 32'(nz), 32'd0);

    // Reset in the middle of a read
    bus_op(1'b1, REG_TONE, 32'd10, rd);
    repeat (12) @(posedge clk);
    #1;
    check("pre_reset_irq", 32'(irq), 32'd1);
    check("pre_reset_snd", 32'(snd_l), 32'd1);
    @(negedge clk);
    bif.bus_req = 1'b1; bif.bus_we = 1'b0; bif.bus_addr = REG_LED;
    #2 rst = 1'b0;
    #1;
    check_all_zero("midreset");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("in_reset_ack%0d", k), 32'(bif.bus_ack), 32'd0);
    end
    @(negedge clk);
    bif.bus_req = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("post_reset_ack%0d", k), 32'(bif.bus_ack), 32'd0);
    end
    bus_op(1'b0, REG_LED, 32'h0, rd);
    check("post_reset_led", rd, 32'h0);
    bus_op(1'b0, REG_IRQ_MASK, 32'h0, rd);
    check("post_reset_mask", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/periph_io_ctrl.md
PERIPH_IO_CTRL -- requirements
Module: periph_io_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 4: consecutive cycles a synchronized input must differ before the debounced state follows it.
REQ-002 clk  in  1  sole clock, all flops rising-edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 switches_and_buttons  in  19  raw asynchronous board inputs.
REQ-005 bus_req  in  1  CPU access request.
REQ-006 bus_we  in  1  1 = write, 0 = read; sampled with bus_req.
REQ-007 bus_addr  in  3  word index into register map.
REQ-008 bus_wdata  in  32  write data.
REQ-009 bus_ack  out  1  one-cycle completion pulse.
REQ-010 bus_rdata  out  32  read data, valid only while bus_ack = 1, else 0.
REQ-011 irq  out  1  level interrupt, = |(IN_EDGE & IRQ_MASK).
REQ-012 LEDs  out  16; RBG_0, RBG_1  out  3 each; sound_L, sound_R  out  1 each.

Function
REQ-013 Register map: 0 IN_STATE (RO, [18:0]); 1 IN_EDGE (W1C, [18:0]); 2 LED (RW, [15:0]); 3 RGB (RW, [2:0] RBG_0 colour, [5:3] RBG_1 colour, [15:8] duty); 4 TONE (RW, [19:0] half-period in clk cycles); 5 IRQ_MASK (RW, [18:0]); 6-7 read 0, writes ignored; unused bits read 0.
REQ-014 Bus FSM states IDLE, ACK; IDLE with bus_req=1 -> ACK, capturing we/addr/wdata; ACK -> IDLE unconditionally.
REQ-015 Write takes effect on the IDLE->ACK edge; bus_ack high exactly one cycle later; read data reflects registers at the accepting edge.
REQ-016 bus_req ignored while in ACK; a held bus_req is re-accepted every second cycle.
REQ-017 Each input bit passes a 2-flop synchronizer before debounce.
REQ-018 Per-bit debounce counter: clears when synchronized bit equals IN_STATE bit; increments otherwise; on reaching DB_CYCLES-1 while still differing, IN_STATE bit takes the new value and counter clears.
REQ-019 IN_EDGE bit sets on a debounced 0->1 transition; cleared by writing 1 to it; simultaneous set and clear: set wins.
REQ-020 LEDs drive LED register directly.
REQ-021 8-bit free-running PWM counter; RBG_x = colour bits when counter < duty, else 0; duty 0 = always off, 255 = on 255 of 256 cycles.
REQ-022 Tone counter counts 0..TONE-1, then wraps and toggles sound_L; TONE = 0 holds sound_L at 0; any TONE write clears counter and sound_L.
REQ-023 sound_R = sound_L.

Reset
REQ-024 On rst low, asynchronously: FSM IDLE, bus_ack 0, bus_rdata 0, irq 0, all registers, synchronizers, debounce/PWM/tone counters 0, so LEDs, RBG_0, RBG_1, sound_L, sound_R = 0.
REQ-025 A transaction in flight at reset is dropped; no ack after release.
REQ-026 After rst rises, first bus_req accepted on the first rising edge of clk.

Structure
REQ-027 Shared package holds register index constants, field positions/widths, FSM state encoding.
REQ-028 Per-bit synchronizer + debouncer is one sub-module, input_debounce, instantiated 19 times (generate).

Verification
REQ-029 Reset: rst low mid-read -> bus_ack never asserts; all outputs 0 within the reset.
REQ-030 Input 19'h00002 held 10 cycles, DB_CYCLES=4 -> IN_STATE reads 0x00000002, IN_EDGE bit1 = 1; a 2-cycle glitch on bit 2 -> no change.
REQ-031 IRQ_MASK=0x2 with IN_EDGE bit1 set -> irq=1; write IN_EDGE 0x2 -> irq 0 the cycle after the accepting edge; write coinciding with a new bit1 rise -> bit stays 1.
REQ-032 Write LED 0xA5A5 -> LEDs=16'hA5A5 at the ack cycle; read back 0x0000A5A5 with bus_ack; held bus_req -> ack every 2 cycles.
REQ-033 Write RGB 0x8005 -> RBG_0=3'b101 for 128 of 256 cycles, RBG_1=0; duty 0 -> always 0.
REQ-034 Write TONE 10 -> sound_L and sound_R square wave, period 20 cycles, first rise 10 cycles after write; TONE 0 -> both held 0.
